// File: rtl/finalproject_cpu_oci_dct_ctrl_pkg.sv
// Shared types and sizing constants for the OCI data-capture-trace sequencer.
package finalproject_cpu_oci_dct_pkg;

  localparam int DCT_ATOM_W = 2;
  localparam int DCT_DEPTH  = 15;
  localparam int DCT_BUF_W  = 30;
  localparam int DCT_CNT_W  = 4;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } dct_state_t;

endpackage

// File: rtl/finalproject_cpu_oci_dct_ctrl_if.sv
// Atom-source and frame-sink handshakes of the DCT sequencer.
interface finalproject_cpu_oci_dct_ctrl_if;
  import finalproject_cpu_oci_dct_pkg::*;

  logic                  atom_valid;
  logic [DCT_ATOM_W-1:0] atom_data;
  logic                  atom_ready;
  logic                  frame_valid;
  logic                  frame_ready;
  logic [DCT_BUF_W-1:0]  frame_data;
  logic [DCT_CNT_W-1:0]  frame_count;

  modport master (
    output atom_valid, atom_data, frame_ready,
    input  atom_ready, frame_valid, frame_data, frame_count
  );

  modport slave (
    input  atom_valid, atom_data, frame_ready,
    output atom_ready, frame_valid, frame_data, frame_count
  );

endinterface

// File: rtl/finalproject_cpu_oci_dct_ctrl_satcnt.sv
// 8-bit saturating event counter, cleared only by the asynchronous reset.
module finalproject_cpu_oci_dct_satcnt (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 8'd0;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/finalproject_cpu_oci_dct_ctrl.sv
// OCI DCT sequencer: packs trace atoms into frames, emits them, drains on test end.
// FINALPROJECT_CPU_OCI_DCT_DROP_EN: keep accepting (and counting as dropped) atoms during EMIT.
module finalproject_cpu_oci_dct_ctrl
  import finalproject_cpu_oci_dct_pkg::*;
#(
  parameter int ATOM_W = DCT_ATOM_W,
  parameter int DEPTH  = DCT_DEPTH,
  parameter int CNT_W  = DCT_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  finalproject_cpu_oci_dct_ctrl_if.slave bus,
  input  logic                      flush,
  input  logic                      test_ending,
  output logic [ATOM_W*DEPTH-1:0]   dct_buffer,
  output logic [CNT_W-1:0]          dct_count,
  output logic                      test_has_ended
`ifdef FINALPROJECT_CPU_OCI_DCT_DROP_EN
  ,
  output logic [7:0]                drop_count
`endif
);

  localparam int BUF_W = ATOM_W * DEPTH;

  dct_state_t        state_reg;
  logic [BUF_W-1:0]  buffer_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              ending_reg;

  logic              accept;
  logic [BUF_W-1:0]  buffer_next;
  logic [CNT_W-1:0]  count_next;

  // Only FILL ever stores an atom; DROP-mode acceptance in EMIT is a discard.
  assign accept = bus.atom_valid && (state_reg == FILL);

  always_comb begin
    buffer_next = buffer_reg;
    count_next  = count_reg;
    if (accept) begin
      buffer_next = {buffer_reg[BUF_W-ATOM_W-1:0], bus.atom_data};
      count_next  = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= FILL;
      buffer_reg <= '0;
      count_reg  <= '0;
      ending_reg <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          buffer_reg <= buffer_next;
          count_reg  <= count_next;
          // test_ending outranks flush; an empty buffer on test end needs no frame.
          if (test_ending) begin
            if (count_next != '0) begin
              state_reg  <= EMIT;
              ending_reg <= 1'b1;
            end else begin
              state_reg <= DONE;
            end
          end else if ((count_next == CNT_W'(DEPTH)) || (flush && (count_next != '0))) begin
            state_reg <= EMIT;
          end
        end
        EMIT: begin
          if (test_ending) begin
            ending_reg <= 1'b1;
          end
          if (bus.frame_ready) begin
            buffer_reg <= '0;
            count_reg  <= '0;
            state_reg  <= (ending_reg || test_ending) ? DONE : FILL;
          end
        end
        DONE: begin
          state_reg <= DONE;
        end
        default: begin
          state_reg <= FILL;
        end
      endcase
    end
  end

`ifdef FINALPROJECT_CPU_OCI_DCT_DROP_EN
  assign bus.atom_ready = (state_reg == FILL) || (state_reg == EMIT);

  finalproject_cpu_oci_dct_satcnt u_drop_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (bus.atom_valid && (state_reg == EMIT)),
    .count   (drop_count)
  );
`else
  assign bus.atom_ready = (state_reg == FILL);
`endif

  assign bus.frame_valid = (state_reg == EMIT);
  assign bus.frame_data  = (state_reg == EMIT) ? buffer_reg : '0;
  assign bus.frame_count = (state_reg == EMIT) ? count_reg : '0;
  assign dct_buffer      = buffer_reg;
  assign dct_count       = count_reg;
  assign test_has_ended  = (state_reg == DONE);

endmodule

// File: tb/tb_finalproject_cpu_oci_dct_ctrl.sv
// Randomized bench for the DCT sequencer against a queue-based frame model.
module tb_finalproject_cpu_oci_dct_ctrl;
  import finalproject_cpu_oci_dct_pkg::*;

`ifdef FINALPROJECT_CPU_OCI_DCT_DROP_EN
  localparam bit DROP_EN = 1'b1;
  logic [7:0] drop_count;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        test_ending = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_has_ended;

  finalproject_cpu_oci_dct_ctrl_if bus ();

  finalproject_cpu_oci_dct_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .flush          (flush),
    .test_ending    (test_ending),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_has_ended (test_has_ended)
`ifdef FINALPROJECT_CPU_OCI_DCT_DROP_EN
    ,
    .drop_count     (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: the pending frame is just the list of accepted atoms.
  int q[$];
  bit m_emit, m_done, m_ending;
  int m_drop;

  function automatic logic [31:0] m_pack();
    logic [31:0] v = 32'd0;
    foreach (q[i]) v = (v << 2) | 32'(q[i]);
    return v;
  endfunction

  function automatic void m_reset();
    q.delete();
    m_emit = 0; m_done = 0; m_ending = 0; m_drop = 0;
  endfunction

  function automatic void m_update(bit av, logic [1:0] ad, bit fl, bit te, bit fr);
    if (m_done) return;
    if (!m_emit) begin
      if (av) q.push_back(int'(ad));
      if (te) begin
        if (q.size() > 0) begin m_emit = 1; m_ending = 1; end
        else m_done = 1;
      end else if (q.size() == 15 || (fl && q.size() > 0)) begin
        m_emit = 1;
      end
    end else begin
      if (av && DROP_EN && m_drop < 255) m_drop++;
      if (te) m_ending = 1;
      if (fr) begin
        q.delete();
        m_emit = 0;
        if (m_ending) m_done = 1;
      end
    end
  endfunction

  task automatic check_outputs();
    bit exp_ready = !m_done && (!m_emit || DROP_EN);
    check_val("atom_ready", 32'(bus.atom_ready), 32'(exp_ready));
    check_val("frame_valid", 32'(bus.frame_valid), 32'(m_emit));
    check_val("frame_data", 32'(bus.frame_data), m_emit ? m_pack() : 32'd0);
    check_val("frame_count", 32'(bus.frame_count), m_emit ? 32'(q.size()) : 32'd0);
    check_val("dct_buffer", 32'(dct_buffer), m_pack());
    check_val("dct_count", 32'(dct_count), 32'(q.size()));
    check_val("test_has_ended", 32'(test_has_ended), 32'(m_done));
`ifdef FINALPROJECT_CPU_OCI_DCT_DROP_EN
    check_val("drop_count", 32'(drop_count), 32'(m_drop));
`endif
  endtask

  // One clock: drive at negedge, model at posedge, compare 1 time unit later.
  task automatic step(input bit av, input logic [1:0] ad, input bit fl, input bit te, input bit fr);
    bus.atom_valid  = av;
    bus.atom_data   = ad;
    flush           = fl;
    test_ending     = te;
    bus.frame_ready = fr;
    @(posedge clk);
    m_update(av, ad, fl, te, fr);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.atom_valid = 0; bus.atom_data = 0; bus.frame_ready = 0;
    flush = 0; test_ending = 0;
    @(negedge clk);
    reset_n = 0;
    m_reset();
    repeat (2) @(negedge clk);
    reset_n = 1;
    #1;
    check_outputs();
  endtask

  initial begin
    int low_cycles;
    bus.atom_valid = 0; bus.atom_data = 0; bus.frame_ready = 0;
    m_reset();
    repeat (2) @(negedge clk);
    reset_n = 1;
    #1;
    check_outputs();
    check_val("reset_ready", 32'(bus.atom_ready), 32'd1);

    // Full frame of 0,1,2,3,... with the sink always ready.
    @(negedge clk);
    low_cycles = 0;
    for (int i = 0; i < 15; i++) begin
      step(1, 2'(i % 4), 0, 0, 1);
      if (!bus.atom_ready) low_cycles++;
    end
    check_val("full_data", 32'(bus.frame_data), 32'h06C6C6C6);
    check_val("full_count", 32'(bus.frame_count), 32'd15);
    step(0, 0, 0, 0, 1);
    if (!bus.atom_ready) low_cycles++;
    check_val("ready_low_cycles", 32'(low_cycles), DROP_EN ? 32'd0 : 32'd1);

    // Partial frame via flush.
    for (int i = 0; i < 5; i++) step(1, 2'b11, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    check_val("flush_data", 32'(bus.frame_data), 32'h3FF);
    check_val("flush_count", 32'(bus.frame_count), 32'd5);
    step(1, 2'b01, 1, 0, 1);
    check_val("flush_cnt_clr", 32'(dct_count), 32'd0);

    // Stalled sink for 10 cycles while the source keeps offering atoms.
    for (int i = 0; i < 15; i++) step(1, 2'($urandom), 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 2'($urandom), $urandom_range(0, 1) == 1, 0, 0);
    step(0, 0, 0, 0, 1);

    // Random traffic without test end.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 15) == 0, 0,
           $urandom_range(0, 2) != 0);

    // Test end coinciding with the 8th atom.
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 2'($urandom), 0, 0, 0);
    step(1, 2'b10, 0, 1, 0);
    check_val("end_count", 32'(bus.frame_count), 32'd8);
    step(0, 0, 0, 0, 1);
    check_val("end_done", 32'(test_has_ended), 32'd1);
    for (int i = 0; i < 10; i++) step(1, 2'($urandom), $urandom_range(0, 1) == 1, 0, 1);
    check_val("end_sticky", 32'(test_has_ended), 32'd1);

    // Test end with an empty buffer.
    do_reset();
    step(0, 0, 0, 1, 1);
    check_val("end_empty_done", 32'(test_has_ended), 32'd1);
    check_val("end_empty_novalid", 32'(bus.frame_valid), 32'd0);

    // Asynchronous reset mid-frame.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 9; i++) step(1, 2'($urandom), 0, 0, 0);
    #2 reset_n = 0;
    #1;
    check_val("arst_count", 32'(dct_count), 32'd0);
    check_val("arst_valid", 32'(bus.frame_valid), 32'd0);
    check_val("arst_ready", 32'(bus.atom_ready), 32'd1);
    check_val("arst_ended", 32'(test_has_ended), 32'd0);
    m_reset();
    @(negedge clk);
    reset_n = 1;
    #1;
    check_outputs();
    @(negedge clk);

    // Random runs ending in test end, bounded drain.
    for (int t = 0; t < 10; t++) begin
      int budget;
      do_reset();
      @(negedge clk);
      for (int i = 0; i < int'($urandom_range(0, 40)); i++)
        step($urandom_range(0, 1) == 1, 2'($urandom), $urandom_range(0, 7) == 0, 0,
             $urandom_range(0, 1) == 1);
      budget = 0;
      while (!m_done && budget < 60) begin
        step($urandom_range(0, 1) == 1, 2'($urandom), $urandom_range(0, 1) == 1, 1,
             (budget > 30) || ($urandom_range(0, 1) == 1));
        budget++;
      end
      check_val("drain_done", 32'(test_has_ended), 32'd1);
    end

    // Long stall with the source saturating the drop counter (when enabled).
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 15; i++) step(1, 2'($urandom), 0, 0, 0);
    for (int i = 0; i < 300; i++) step(1, 2'($urandom), 0, 0, 0);
`ifdef FINALPROJECT_CPU_OCI_DCT_DROP_EN
    check_val("drop_sat", 32'(drop_count), 32'd255);
`endif
    check_val("stall_count", 32'(bus.frame_count), 32'd15);
    step(0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
